// File: rtl/shared_exp_scheduler.sv
// Multi-beat MX shared-exponent scheduler: folds `lanes` exponents per beat
// through a max tree into a running block maximum, then presents one result.
module shared_exp_max2 #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);
  assign y = (a > b) ? a : b;
endmodule

module shared_exp_scheduler #(
  parameter int width     = 8,
  parameter int length    = 32,
  parameter int lanes     = 8,
  parameter int elem_emax = 0,
  localparam int BEATS    = length / lanes,
  localparam int IW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [width-1:0] i_exps [lanes],
  output logic             o_valid,
  input  logic             i_ready,
  output logic [width-1:0] o_e_max,
  output logic [width-1:0] o_e_shared,
  output logic [IW-1:0]    o_beat_idx
);
  localparam int LV = $clog2(lanes);
  localparam logic [width-1:0] EMAX = width'(elem_emax);
  localparam logic [IW-1:0]    LAST = IW'(BEATS - 1);

  generate
    if (lanes < 1 || (lanes & (lanes - 1)) != 0) begin : g_bad_lanes
      $error("shared_exp_scheduler: lanes must be a power of two");
    end
    if ((length % lanes) != 0 || length < lanes) begin : g_bad_length
      $error("shared_exp_scheduler: length must be a multiple of lanes");
    end
    if (elem_emax < 0 || longint'(elem_emax) >= (longint'(1) << width)) begin : g_bad_emax
      $error("shared_exp_scheduler: elem_emax does not fit in width bits");
    end
  endgenerate

  // Level l of the tree holds lanes>>l partial maxima; level LV is the beat max.
  generate
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
      logic [width-1:0] v [lanes >> l];
      if (l == 0) begin : g_leaf
        for (genvar i = 0; i < lanes; i++) begin : g_in
          assign v[i] = i_exps[i];
        end
      end else begin : g_node
        for (genvar i = 0; i < (lanes >> l); i++) begin : g_max
          shared_exp_max2 #(.width(width)) u_max (
            .a (g_lvl[l-1].v[2*i]),
            .b (g_lvl[l-1].v[2*i+1]),
            .y (v[i])
          );
        end
      end
    end
  endgenerate

  logic [width-1:0] beat_max, nxt_acc, nxt_shared, acc;
  logic [IW-1:0]    beat_cnt;

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;
  state_t state;

  assign beat_max   = g_lvl[LV].v[0];
  // Beat 0 reloads so the previous block's maximum never leaks forward.
  assign nxt_acc    = (beat_cnt == '0) ? beat_max : ((acc > beat_max) ? acc : beat_max);
  assign nxt_shared = (nxt_acc > EMAX) ? nxt_acc - EMAX : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ACCUM;
      beat_cnt   <= '0;
      acc        <= '0;
      o_e_shared <= '0;
    end else begin
      case (state)
        ACCUM: if (i_valid) begin
          acc <= nxt_acc;
          if (beat_cnt == LAST) begin
            beat_cnt   <= '0;
            o_e_shared <= nxt_shared;
            state      <= OUT;
          end else begin
            beat_cnt <= beat_cnt + IW'(1);
          end
        end
        OUT: if (i_ready) state <= ACCUM;
      endcase
    end
  end

  assign o_ready    = (state == ACCUM);
  assign o_valid    = (state == OUT);
  assign o_e_max    = acc;
  assign o_beat_idx = beat_cnt;
endmodule

// File: doc/shared_exp_scheduler.md
Name: shared_exp_scheduler

Overview:
- Sequences one MX block of `length` unsigned exponents through a narrow `lanes`-wide max tree, one beat per cycle over several beats.
- Accumulates the running maximum across beats and emits two results per block: the block maximum exponent and the MX shared exponent.
- Sits between the element-exponent extraction stage and the quantiser.
- Replaces a full-width tree when input bandwidth is limited.

Parameters:
- width, 8: bit width of each exponent.
- length, 32: exponents per MX block. Must be a multiple of lanes.
- lanes, 8: exponents accepted per beat. Power of two, 1 or greater.
- elem_emax, 0: element-format maximum exponent. It is subtracted from the block max to form the shared exponent.

Ports:
- i_clk, input, 1: clock. All logic is on the rising edge.
- i_rst, input, 1: synchronous, active-high reset.
- i_valid, input, 1: a beat of exponents is present.
- o_ready, output, 1: the block can accept a beat.
- i_exps, input, width x [lanes]: unpacked array of exponents for this beat.
- o_valid, output, 1: a block result is present.
- i_ready, input, 1: the downstream stage accepts the result.
- o_e_max, output, width: unsigned maximum over all `length` exponents of the block.
- o_e_shared, output, width: saturating o_e_max minus elem_emax.
- o_beat_idx, output, clog2(length/lanes) (min 1): index of the next beat expected.

Behaviour:
- Derived constant: BEATS = length/lanes.
- Beat max: a combinational unsigned max over the `lanes` entries of i_exps, built as a tree. Ties are irrelevant because values are equal. When lanes = 1 the beat max is i_exps[0].
- FSM has two states, ACCUM and OUT.
- ACCUM:
  - o_ready = 1 and o_valid = 0.
  - A beat is accepted on a cycle with i_valid & o_ready.
  - On an accepted beat with beat_cnt == 0: acc <= beat max. The previous block's value is never merged in.
  - On an accepted beat with beat_cnt > 0: acc <= max(acc, beat max).
  - beat_cnt increments on each accepted beat.
  - When beat_cnt == BEATS-1 on an accepted beat: beat_cnt <= 0 and state <= OUT.
  - With i_valid = 0, acc and beat_cnt hold. Gaps between beats are legal.
- OUT:
  - o_ready = 0 and o_valid = 1.
  - o_e_max = acc.
  - o_e_shared = (acc > elem_emax) ? acc - elem_emax : 0. Registered or combinational from acc; either way it is stable in OUT.
  - When i_ready = 1: state <= ACCUM on the next edge, and o_valid falls.
  - When i_ready = 0: hold. o_valid, o_e_max and o_e_shared stay constant until accepted.
  - Beats presented while in OUT are not accepted, because o_ready = 0.
- Latency: o_valid rises on the cycle after the last beat is accepted.
- Throughput: at most one block per BEATS+1 cycles. There is one bubble cycle in OUT with i_ready tied high.
- o_ready depends only on state. It has no combinational path from i_valid or i_ready.
- o_beat_idx = beat_cnt. It reads 0 in OUT.
- Reset:
  - Takes effect the cycle i_rst is sampled high.
  - state = ACCUM, beat_cnt = 0, acc = 0, o_valid = 0, o_e_max = 0, o_e_shared = 0.
  - Reset mid-block discards the partial maximum.
  - Reset in OUT drops the pending result without handshake.
  - A beat with i_valid high in the same cycle as i_rst is not accepted.
- BEATS = 1: every accepted beat moves directly to OUT.
- Arithmetic:
  - All comparisons are unsigned at width bits.
  - The all-ones exponent is treated as an ordinary value; no NaN/Inf special casing.
  - elem_emax >= 2^width is illegal and flagged by an elaboration-time assertion.
- Illegal parameterisation fails at elaboration: length % lanes != 0, or lanes not a power of two.

Test Plan:
- Defaults, elem_emax = 2, i_ready high.
  - Stimulus: 4 beats where beat 2 lane 5 = 200 and all other exponents are 0..100.
  - Response: o_valid one cycle after beat 3; o_e_max = 200, o_e_shared = 198; o_ready low for exactly that one cycle.
- Back-to-back blocks.
  - Stimulus: block A max = 90, then block B with all exponents 10.
  - Response: block B reports o_e_max = 10 (acc reloaded on beat 0, not 90); o_e_shared = 8.
- Backpressure.
  - Stimulus: hold i_ready = 0 for 5 cycles in OUT while driving i_valid = 1 with new data.
  - Response: o_valid and o_e_max stay constant; no beat accepted; o_beat_idx = 0; the result is accepted on the first i_ready = 1.
- Saturation and extremes.
  - Stimulus: elem_emax = 2 with all exponents 1.
  - Response: o_e_max = 1, o_e_shared = 0.
  - Stimulus: a single 255 in beat 0 lane 0.
  - Response: o_e_max = 255.
- Gaps and reset mid-block.
  - Stimulus: insert i_valid = 0 bubbles between beats, checking o_beat_idx sequences 0,1,2,3. Then assert i_rst after beat 1 of a block containing 250, and follow with a clean block of max 7.
  - Response: o_valid stays 0 through reset; o_e_max = 7 (the 250 is discarded).
- Parameter sweep.
  - Stimulus: lanes = 1 and lanes = 32 (BEATS = 1) with random data.
  - Response: o_e_max matches a reference max on every block; latency equals the number of beats plus 1.
